// File: rtl/controle_if.sv
// Opcode-in / control-out bundle between decode and the datapath.
interface controle_if;
  logic [5:0] opcode;
  logic [1:0] c_ALUOp;
  logic       c_fonte_ula;
  logic [2:0] c_desvio;
  logic [1:0] c_memoria;
  logic       c_memtoreg;
  logic       c_escrever_reg;
  logic       c_reg_destino;
  logic       c_invalido;

  // Instruction decode side: supplies the opcode, consumes controls.
  modport master (
    output opcode,
    input  c_ALUOp, c_fonte_ula, c_desvio, c_memoria,
    input  c_memtoreg, c_escrever_reg, c_reg_destino, c_invalido
  );

  // Control unit side: consumes the opcode, drives controls.
  modport slave (
    input  opcode,
    output c_ALUOp, c_fonte_ula, c_desvio, c_memoria,
    output c_memtoreg, c_escrever_reg, c_reg_destino, c_invalido
  );
endinterface

// File: rtl/controle.sv
// Main MIPS32 control decoder: opcode -> registered datapath controls.
module controle (
  input  logic       clock,
  input  logic       reset,
  controle_if.slave  bus
);

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned DESVIO_W = 3;
  localparam int unsigned MEM_W    = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_R   = 2'b10;

  localparam logic [DESVIO_W-1:0] DV_SEQ = 3'b000;
  localparam logic [DESVIO_W-1:0] DV_BEQ = 3'b001;
  localparam logic [DESVIO_W-1:0] DV_BNE = 3'b010;
  localparam logic [DESVIO_W-1:0] DV_J   = 3'b011;
  localparam logic [DESVIO_W-1:0] DV_JAL = 3'b100;

  localparam logic [MEM_W-1:0] MEM_IDLE  = 2'b00;
  localparam logic [MEM_W-1:0] MEM_READ  = 2'b01;
  localparam logic [MEM_W-1:0] MEM_WRITE = 2'b10;

  logic [ALUOP_W-1:0]  aluop_c;
  logic                fonte_ula_c;
  logic [DESVIO_W-1:0] desvio_c;
  logic [MEM_W-1:0]    memoria_c;
  logic                memtoreg_c;
  logic                escrever_reg_c;
  logic                reg_destino_c;
  logic                invalido_c;

  // Combinational decode; unknown opcodes fall back to NOP-safe zeros.
  always_comb begin
    aluop_c        = ALU_ADD;
    fonte_ula_c    = 1'b0;
    desvio_c       = DV_SEQ;
    memoria_c      = MEM_IDLE;
    memtoreg_c     = 1'b0;
    escrever_reg_c = 1'b0;
    reg_destino_c  = 1'b0;
    invalido_c     = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        aluop_c        = ALU_R;
        escrever_reg_c = 1'b1;
        reg_destino_c  = 1'b1;
      end
      OP_ADDI: begin
        fonte_ula_c    = 1'b1;
        escrever_reg_c = 1'b1;
      end
      OP_LW: begin
        fonte_ula_c    = 1'b1;
        memoria_c      = MEM_READ;
        memtoreg_c     = 1'b1;
        escrever_reg_c = 1'b1;
      end
      OP_SW: begin
        fonte_ula_c = 1'b1;
        memoria_c   = MEM_WRITE;
      end
      OP_BEQ: begin
        aluop_c  = ALU_SUB;
        desvio_c = DV_BEQ;
      end
      OP_BNE: begin
        aluop_c  = ALU_SUB;
        desvio_c = DV_BNE;
      end
      OP_J: begin
        desvio_c = DV_J;
      end
      // Datapath forces $31 and PC+4 on JAL, so rt select is left at 0.
      OP_JAL: begin
        desvio_c       = DV_JAL;
        escrever_reg_c = 1'b1;
      end
      default: begin
        invalido_c = 1'b1;
      end
    endcase
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.c_ALUOp        <= ALU_ADD;
      bus.c_fonte_ula    <= 1'b0;
      bus.c_desvio       <= DV_SEQ;
      bus.c_memoria      <= MEM_IDLE;
      bus.c_memtoreg     <= 1'b0;
      bus.c_escrever_reg <= 1'b0;
      bus.c_reg_destino  <= 1'b0;
      bus.c_invalido     <= 1'b0;
    end else begin
      bus.c_ALUOp        <= aluop_c;
      bus.c_fonte_ula    <= fonte_ula_c;
      bus.c_desvio       <= desvio_c;
      bus.c_memoria      <= memoria_c;
      bus.c_memtoreg     <= memtoreg_c;
      bus.c_escrever_reg <= escrever_reg_c;
      bus.c_reg_destino  <= reg_destino_c;
      bus.c_invalido     <= invalido_c;
    end
  end

endmodule

// File: tb/tb_controle.sv
// Self-checking bench for controle: directed table, corner sequences, random.
module tb_controle;

  logic clock;
  logic reset;
  controle_if bus ();

  controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed control word: ALUOp[11:10] fonte[9] desvio[8:6] mem[5:4] m2r[3] wr[2] rd[1] inv[0]
  localparam logic [11:0] W_ZERO = 12'b00_0_000_00_0_0_0_0;
  localparam logic [11:0] W_R    = 12'b10_0_000_00_0_1_1_0;
  localparam logic [11:0] W_ADDI = 12'b00_1_000_00_0_1_0_0;
  localparam logic [11:0] W_LW   = 12'b00_1_000_01_1_1_0_0;
  localparam logic [11:0] W_SW   = 12'b00_1_000_10_0_0_0_0;
  localparam logic [11:0] W_BEQ  = 12'b01_0_001_00_0_0_0_0;
  localparam logic [11:0] W_BNE  = 12'b01_0_010_00_0_0_0_0;
  localparam logic [11:0] W_J    = 12'b00_0_011_00_0_0_0_0;
  localparam logic [11:0] W_JAL  = 12'b00_0_100_00_0_1_0_0;
  localparam logic [11:0] W_INV  = 12'b00_0_000_00_0_0_0_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] rows[logic [5:0]];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [11:0] actual();
    return {bus.c_ALUOp, bus.c_fonte_ula, bus.c_desvio, bus.c_memoria,
            bus.c_memtoreg, bus.c_escrever_reg, bus.c_reg_destino, bus.c_invalido};
  endfunction

  // Reference: reset clears, known opcodes look up their row, others flag invalid.
  function automatic logic [11:0] model(input logic rst, input logic [5:0] op);
    if (!rst) return W_ZERO;
    if (rows.exists(op)) return rows[op];
    return W_INV;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive at negedge, sample just after the next rising edge.
  task automatic step(input logic rst, input logic [5:0] op, input string name, input logic [11:0] exp);
    @(negedge clock);
    reset     = rst;
    bus.opcode = op;
    @(posedge clock);
    #1;
    check(name, actual(), exp);
  endtask

  initial begin
    logic [11:0] a;
    logic [5:0]  rop;
    logic        rrst;

    rows[6'b000000] = W_R;
    rows[6'b001000] = W_ADDI;
    rows[6'b100011] = W_LW;
    rows[6'b101011] = W_SW;
    rows[6'b000100] = W_BEQ;
    rows[6'b000101] = W_BNE;
    rows[6'b000010] = W_J;
    rows[6'b000011] = W_JAL;

    reset      = 1'b0;
    bus.opcode = 6'b000000;

    // Reset, release, full decode sequence, invalid opcodes, reset while LW held.
    vecs.push_back('{1'b0, 6'b000000, W_ZERO});
    vecs.push_back('{1'b0, 6'b000000, W_ZERO});
    vecs.push_back('{1'b1, 6'b000000, W_R});
    vecs.push_back('{1'b1, 6'b001000, W_ADDI});
    vecs.push_back('{1'b1, 6'b000011, W_JAL});
    vecs.push_back('{1'b1, 6'b000010, W_J});
    vecs.push_back('{1'b1, 6'b000101, W_BNE});
    vecs.push_back('{1'b1, 6'b000100, W_BEQ});
    vecs.push_back('{1'b1, 6'b100011, W_LW});
    vecs.push_back('{1'b1, 6'b101011, W_SW});
    vecs.push_back('{1'b1, 6'b111111, W_INV});
    vecs.push_back('{1'b1, 6'b001101, W_INV});
    vecs.push_back('{1'b1, 6'b001000, W_ADDI});
    vecs.push_back('{1'b0, 6'b100011, W_ZERO});
    vecs.push_back('{1'b1, 6'b100011, W_LW});

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].op, $sformatf("vec%0d", i), vecs[i].exp);

    // SW held three edges stays constant.
    for (int i = 0; i < 3; i++)
      step(1'b1, 6'b101011, $sformatf("sw_hold%0d", i), W_SW);

    // Opcode toggling mid-cycle must not reach the outputs before the edge.
    #2;
    bus.opcode = 6'b000000;
    #1;
    check("midcycle_a", actual(), W_SW);
    bus.opcode = 6'b111111;
    @(negedge clock);
    check("midcycle_b", actual(), W_SW);
    @(posedge clock);
    #1;
    check("midcycle_edge", actual(), W_INV);

    // Reset wins over a valid opcode, then first released edge loads with no bubble.
    step(1'b0, 6'b000011, "rst_over_jal", W_ZERO);
    step(1'b1, 6'b000011, "jal_after_rst", W_JAL);

    // Randomized stimulus biased toward supported opcodes.
    for (int i = 0; i < 300; i++) begin
      rrst = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0: rop = 6'b000000;
        1: rop = 6'b001000;
        2: rop = 6'b100011;
        3: rop = 6'b101011;
        4: rop = 6'b000100;
        5: rop = 6'b000101;
        6: rop = 6'b000010;
        7: rop = 6'b000011;
        default: rop = 6'($urandom);
      endcase
      step(rrst, rop, $sformatf("rand%0d op=%b rst=%b", i, rop, rrst), model(rrst, rop));
      a = actual();
      check("inv_mem", {11'd0, a[5:4] == 2'b11}, 12'd0);
      check("inv_desvio", {11'd0, a[8:6] > 3'd4}, 12'd0);
      check("inv_m2r", {11'd0, a[3] && (a[5:4] != 2'b01)}, 12'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
